// File: rtl/tinymcu_bus_pkg.sv
// tinymcu_bus_pkg: shared MMIO bus widths, idle device code and arbiter state type.
package tinymcu_bus_pkg;
  localparam int MMIO_ADDR_W = 16;
  localparam int MMIO_DATA_W = 8;
  localparam int MMIO_DEV_W  = 3;
  localparam logic [MMIO_DEV_W-1:0] IDLE_DEV = 3'b111;
  typedef enum logic [1:0] {IDLE, ISSUE_WR, ISSUE_RD, WAIT_RD} arb_state_e;
endpackage

// File: rtl/mmio_arbiter_if.sv
// mmio_arbiter_if: requester handshake plus the shared peripheral bus.
interface mmio_arbiter_if #(parameter int NUM_REQ = 2);
  import tinymcu_bus_pkg::*;
  logic [NUM_REQ-1:0]                  req_valid, req_wr, req_ready, rsp_valid;
  logic [NUM_REQ-1:0][MMIO_DEV_W-1:0]  req_dev;
  logic [NUM_REQ-1:0][MMIO_ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][MMIO_DATA_W-1:0] req_wdata;
  logic [MMIO_DATA_W-1:0]              rsp_rdata, mmio_wdata, mmio_rdata;
  logic [MMIO_DEV_W-1:0]               device_select;
  logic [MMIO_ADDR_W-1:0]              mmio_addr;
  logic                                mmio_wr, mmio_rd;
  modport slave (
    input  req_valid, req_wr, req_dev, req_addr, req_wdata, mmio_rdata,
    output req_ready, rsp_valid, rsp_rdata, device_select, mmio_addr, mmio_wdata, mmio_wr, mmio_rd
  );
  modport master (
    output req_valid, req_wr, req_dev, req_addr, req_wdata, mmio_rdata,
    input  req_ready, rsp_valid, rsp_rdata, device_select, mmio_addr, mmio_wdata, mmio_wr, mmio_rd
  );
endinterface

// File: rtl/mmio_arbiter_rr_picker.sv
// rr_picker: first valid requester after ptr_i (wrapping), as one-hot grant and index.
module rr_picker #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  int j;
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    // Scan furthest-first so the nearest valid after the pointer overwrites last.
    for (int k = N; k >= 1; k--) begin
      j = (int'(ptr_i) + k) % N;
      if (valid_i[j]) begin
        grant_o    = '0;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
        any_o      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mmio_arbiter.sv
// mmio_arbiter: round-robin sharing of the MMIO peripheral bus; writes stream 1/cycle,
// a read holds the bus until its registered response returns.
module mmio_arbiter import tinymcu_bus_pkg::*; #(
  parameter int NUM_REQ    = 2,
  parameter int RD_LATENCY = 1,
  parameter logic [MMIO_DEV_W-1:0] IDLE_DEV = tinymcu_bus_pkg::IDLE_DEV
) (
  input logic           clk,
  input logic           rst,
  mmio_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(RD_LATENCY + 1);
  if (RD_LATENCY < 1) begin : g_bad_latency
    $error("mmio_arbiter: RD_LATENCY must be at least 1");
  end
  arb_state_e             state_q, state_d;
  logic [IW-1:0]          rr_q, rr_d, idx;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [MMIO_DEV_W-1:0]  dev_q, dev_d;
  logic [MMIO_ADDR_W-1:0] addr_q, addr_d;
  logic [MMIO_DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d, grant;
  logic                   any, win_open;
  rr_picker #(.N(NUM_REQ)) u_pick (
    .valid_i(bus.req_valid), .ptr_i(rr_q), .grant_o(grant), .idx_o(idx), .any_o(any)
  );
  assign win_open          = state_q == IDLE || state_q == ISSUE_WR;
  assign bus.req_ready     = win_open ? grant : '0;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rdata_q;
  assign bus.device_select = dev_q;
  assign bus.mmio_addr     = addr_q;
  assign bus.mmio_wdata    = wdata_q;
  assign bus.mmio_wr       = state_q == ISSUE_WR;
  assign bus.mmio_rd       = state_q == ISSUE_RD;
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    dev_d       = dev_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = '0;
    if (win_open) begin
      state_d = !any ? IDLE : (bus.req_wr[idx] ? ISSUE_WR : ISSUE_RD);
      rr_d    = any ? idx : rr_q;
      dev_d   = any ? bus.req_dev[idx] : IDLE_DEV;
      addr_d  = any ? bus.req_addr[idx] : '0;
      wdata_d = any ? bus.req_wdata[idx] : '0;
    end else if (state_q == ISSUE_RD) begin
      cnt_d   = CW'(RD_LATENCY);
      state_d = WAIT_RD;
    end else begin
      // rr_q still names the read's owner: nothing else is accepted while it is pending.
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d           = IDLE;
        rdata_d           = bus.mmio_rdata;
        rsp_valid_d[rr_q] = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= IW'(NUM_REQ - 1);
      cnt_q       <= '0;
      dev_q       <= IDLE_DEV;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      dev_q       <= dev_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
endmodule

// File: tb/tb_mmio_arbiter.sv
// tb_mmio_arbiter: random and directed traffic against a round-robin reference model with
// scoreboard queues for bus transactions and read responses.
module tb_mmio_arbiter;
  localparam int NR  = 2;
  localparam int LAT = 1;
  typedef struct {int cyc; logic wr; logic [2:0] dev; logic [15:0] addr; logic [7:0] wdata; int owner;} txn_t;
  typedef struct {int cyc; int owner; logic [7:0] data;} rsp_t;
  logic clk = 0, rst = 0, run = 0;
  int cyc = 0, compared = 0, mismatched = 0, last = NR - 1, win;
  bit busy;
  txn_t tq[$];
  rsp_t rq[$];
  txn_t t;
  rsp_t rs;
  logic [7:0] dl1 [1];
  logic [7:0] dl3 [3];
  mmio_arbiter_if #(.NUM_REQ(NR)) bus ();
  mmio_arbiter_if #(.NUM_REQ(NR)) bus3 ();
  mmio_arbiter #(.NUM_REQ(NR), .RD_LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  mmio_arbiter #(.NUM_REQ(NR), .RD_LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] f(input logic [2:0] d, input logic [15:0] a);
    return {d, 5'b0} ^ a[7:0] ^ a[15:8] ^ 8'hC4;
  endfunction
  // Registered peripherals: data valid exactly LAT cycles after the strobe, complement otherwise.
  always @(posedge clk) dl1[0] <= bus.mmio_rd ? f(bus.device_select, bus.mmio_addr) : ~f(bus.device_select, bus.mmio_addr);
  assign bus.mmio_rdata = dl1[0];
  always @(posedge clk) begin
    dl3[0] <= bus3.mmio_rd ? f(bus3.device_select, bus3.mmio_addr) : ~f(bus3.device_select, bus3.mmio_addr);
    dl3[1] <= dl3[0];
    dl3[2] <= dl3[1];
  end
  assign bus3.mmio_rdata = dl3[2];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      tq.delete();
      rq.delete();
      busy = 0;
      last = NR - 1;
    end else begin
      if (bus.mmio_wr || bus.mmio_rd) begin
        if (tq.size() == 0) check("unexpected_strobe", 32'({bus.mmio_wr, bus.mmio_rd}), 32'(0));
        else begin
          t = tq.pop_front();
          check("strobe_cycle", 32'(cyc), 32'(t.cyc));
          check("strobe_kind", 32'({bus.mmio_wr, bus.mmio_rd}), 32'({t.wr, !t.wr}));
          check("bus_dev", 32'(bus.device_select), 32'(t.dev));
          check("bus_addr", 32'(bus.mmio_addr), 32'(t.addr));
          if (t.wr) check("bus_wdata", 32'(bus.mmio_wdata), 32'(t.wdata));
          else rq.push_back('{cyc + LAT + 1, t.owner, f(t.dev, t.addr)});
        end
      end else if (!busy && bus.rsp_valid == 0)
        check("idle_bus", 32'({bus.device_select, bus.mmio_addr, bus.mmio_wdata}), 32'({3'b111, 24'h0}));
      if (bus.rsp_valid != 0) begin
        if (rq.size() == 0) check("unexpected_rsp", 32'(bus.rsp_valid), 32'(0));
        else begin
          rs = rq.pop_front();
          check("rsp_cycle", 32'(cyc), 32'(rs.cyc));
          check("rsp_owner", 32'(bus.rsp_valid), 32'(1) << rs.owner);
          check("rsp_rdata", 32'(bus.rsp_rdata), 32'(rs.data));
        end
        busy = 0;
      end
      win = -1;
      if (!busy)
        for (int k = 1; k <= NR; k++)
          if (win < 0 && bus.req_valid[(last + k) % NR]) win = (last + k) % NR;
      check("ready", 32'(bus.req_ready), win < 0 ? 32'(0) : 32'(1) << win);
      if (win >= 0) begin
        last = win;
        tq.push_back('{cyc + 1, bus.req_wr[win], bus.req_dev[win], bus.req_addr[win], bus.req_wdata[win], win});
        if (!bus.req_wr[win]) busy = 1;
      end
    end
  end
  task automatic drive(input int r);
    bit got, drop;
    int n;
    while (run) begin
      bus.req_wr[r]    = $urandom_range(0, 3) != 0;
      bus.req_dev[r]   = 3'($urandom_range(0, 6));
      bus.req_addr[r]  = 16'($urandom);
      bus.req_wdata[r] = 8'($urandom);
      bus.req_valid[r] = 1'b1;
      n = 0; got = 0; drop = 0;
      while (!got && !drop && n < 200) begin
        @(negedge clk);
        got  = bus.req_ready[r];
        drop = !got && $urandom_range(0, 24) == 0;
        @(posedge clk); #1;
        n++;
      end
      if (!got && !drop) begin
        compared++; mismatched++;
        $display("FAIL req%0d_wait: no ready within 200 cycles", r);
      end
      if (!got || $urandom_range(0, 2) == 0) begin
        bus.req_valid[r] = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    end
    bus.req_valid[r] = 1'b0;
  endtask
  task automatic set_req(input int r, input logic wr, input logic [2:0] d, input logic [15:0] a, input logic [7:0] w);
    bus.req_wr[r] = wr; bus.req_dev[r] = d; bus.req_addr[r] = a; bus.req_wdata[r] = w; bus.req_valid[r] = 1'b1;
  endtask
  task automatic reset_outputs(input string nm);
    check({nm, "_dev"}, 32'(bus.device_select), 32'(3'b111));
    check({nm, "_addr_wdata"}, 32'({bus.mmio_addr, bus.mmio_wdata}), 32'(0));
    check({nm, "_strobes"}, 32'({bus.mmio_wr, bus.mmio_rd}), 32'(0));
    check({nm, "_rsp"}, 32'({bus.rsp_valid, bus.rsp_rdata}), 32'(0));
  endtask
  initial begin
    bus.req_valid = '0; bus.req_wr = '0; bus.req_dev = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus3.req_valid = '0; bus3.req_wr = '0; bus3.req_dev = '0; bus3.req_addr = '0; bus3.req_wdata = '0;
    #1 rst = 1;
    #1 reset_outputs("reset");
    check("reset_dev3", 32'(bus3.device_select), 32'(3'b111));
    repeat (2) @(posedge clk);
    #1 rst = 0;
    // Single read from req0, peripheral returns A5.
    @(posedge clk); #1 set_req(0, 0, 3'd3, 16'd1, 8'h00);
    @(negedge clk); check("t1_ready", 32'(bus.req_ready), 32'(2'b01));
    @(posedge clk); #1 bus.req_valid[0] = 0;
    @(negedge clk); check("t1_rd_strobe", 32'(bus.mmio_rd), 32'(1));
    @(negedge clk); check("t1_no_rsp_yet", 32'(bus.rsp_valid), 32'(0));
    @(negedge clk); check("t1_rsp", 32'({bus.rsp_valid, bus.rsp_rdata}), 32'({2'b01, 8'hA5}));
    // Write burst from req1.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 set_req(1, 1, 3'd2, 16'(i), 8'(8'h10 + i));
      @(negedge clk); check("t2_ready", 32'(bus.req_ready), 32'(2'b10));
    end
    @(posedge clk); #1 bus.req_valid[1] = 0;
    repeat (3) @(posedge clk);
    #1 run = 1;
    fork
      drive(0);
      drive(1);
      begin repeat (1500) @(posedge clk); run = 0; end
    join
    repeat (8) @(posedge clk);
    // Read blocking: req1 write waits for req0's response cycle.
    #1 set_req(0, 0, 3'd1, 16'h0042, 8'h00);
    @(negedge clk);
    @(posedge clk); #1 bus.req_valid[0] = 0; set_req(1, 1, 3'd4, 16'h0100, 8'h77);
    @(negedge clk); check("t4_blocked1", 32'(bus.req_ready), 32'(0));
    @(negedge clk); check("t4_blocked2", 32'(bus.req_ready), 32'(0));
    @(negedge clk); check("t4_release", 32'({bus.req_ready, bus.rsp_valid}), 32'({2'b10, 2'b01}));
    @(posedge clk); #1 bus.req_valid[1] = 0;
    repeat (3) @(posedge clk);
    // Reset while the read is in WAIT_RD.
    #1 set_req(0, 0, 3'd5, 16'h0007, 8'h00);
    @(negedge clk);
    @(posedge clk); #1 bus.req_valid[0] = 0;
    @(posedge clk); #1 rst = 1;
    #1 reset_outputs("midrd_reset");
    @(posedge clk); #1 rst = 0;
    repeat (4) @(posedge clk);
    #1 set_req(0, 1, 3'd0, 16'h0011, 8'h22); set_req(1, 1, 3'd1, 16'h0033, 8'h44);
    @(negedge clk); check("t5_req0_first", 32'(bus.req_ready), 32'(2'b01));
    @(posedge clk); #1 bus.req_valid = '0;
    repeat (3) @(posedge clk);
    // Quiet bus for 20 cycles.
    repeat (20) begin
      @(negedge clk); check("t6_idle", 32'({bus.device_select, bus.mmio_wr, bus.mmio_rd}), 32'({3'b111, 2'b00}));
    end
    // RD_LATENCY=3 instance: rsp_valid five cycles after accept.
    @(posedge clk); #1
    bus3.req_wr[0] = 0; bus3.req_dev[0] = 3'd3; bus3.req_addr[0] = 16'd1; bus3.req_valid[0] = 1;
    @(negedge clk); check("lat3_ready", 32'(bus3.req_ready), 32'(2'b01));
    @(posedge clk); #1 bus3.req_valid[0] = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("lat3_rd", 32'(bus3.mmio_rd), 32'(k == 1));
      check("lat3_rsp_valid", 32'(bus3.rsp_valid), k == 5 ? 32'(1) : 32'(0));
      if (k == 5) check("lat3_rdata", 32'(bus3.rsp_rdata), 32'(8'hA5));
    end
    repeat (4) @(posedge clk);
    check("bus_queue_empty", 32'(tq.size()), 32'(0));
    check("rsp_queue_empty", 32'(rq.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "timeout");
  end
endmodule
